// File: rtl/vec_packer.sv
// Packs a stream of signed 8-bit samples into 4-sample vectors
// and buffers whole vectors in a small FIFO for a downstream consumer.
module vec_packer #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          arst_n,
  input  logic signed [7:0]             din,
  input  logic                          din_valid,
  output logic                          din_ready,
  input  logic                          flush,
  output logic signed [7:0]             X1,
  output logic signed [7:0]             X2,
  output logic signed [7:0]             X3,
  output logic signed [7:0]             X4,
  output logic                          valid,
  input  logic                          ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic [1:0]                    partial
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {
    COLLECT,
    LAST,
    STALL
  } state_t;

  state_t state, state_nxt;

  logic [31:0]       mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic signed [7:0] slot0, slot1, slot2;
  logic [1:0]        cnt, cnt_nxt;
  logic              rdy_en;
  logic              full, pop, push;
  logic              space, accept;
  logic [31:0]       vec, head;

  assign full   = level == LW'(FIFO_DEPTH);
  assign valid  = level != '0;
  assign pop    = valid && ready;
  assign space  = !full || pop;

  // rdy_en keeps din_ready low in reset and for the first
  // cycle after release.
  assign din_ready = rdy_en && (state == COLLECT || space);
  assign accept    = din_valid && din_ready;

  // A held-off flush (no space) still lets the sample land.
  assign push = (accept && cnt == 2'd3)
             || (flush && space && (accept || cnt != 2'd0));

  always_comb begin
    vec = '0;
    if (cnt > 2'd0)
      vec[7:0] = slot0;
    else if (accept)
      vec[7:0] = din;
    if (cnt > 2'd1)
      vec[15:8] = slot1;
    else if (accept && cnt == 2'd1)
      vec[15:8] = din;
    if (cnt > 2'd2)
      vec[23:16] = slot2;
    else if (accept && cnt == 2'd2)
      vec[23:16] = din;
    if (accept && cnt == 2'd3)
      vec[31:24] = din;
  end

  always_comb begin
    cnt_nxt = cnt;
    if (push)
      cnt_nxt = 2'd0;
    else if (accept)
      cnt_nxt = cnt + 2'd1;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      COLLECT: begin
        if (accept && !push && cnt == 2'd2)
          state_nxt = LAST;
      end
      LAST: begin
        if (push)
          state_nxt = COLLECT;
        else if (!space)
          state_nxt = STALL;
      end
      STALL: begin
        if (push)
          state_nxt = COLLECT;
        else if (space)
          state_nxt = LAST;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state  <= COLLECT;
      cnt    <= 2'd0;
      rdy_en <= 1'b0;
      slot0  <= '0;
      slot1  <= '0;
      slot2  <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      rdy_en <= 1'b1;
      if (accept && !push) begin
        unique case (1'b1)
          cnt == 2'd0: slot0 <= din;
          cnt == 2'd1: slot1 <= din;
          default:     slot2 <= din;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      unique case (1'b1)
        push && !pop: level <= level + LW'(1);
        pop && !push: level <= level - LW'(1);
        default:      level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= vec;
  end

  assign head    = valid ? mem[rd_ptr] : '0;
  assign X1      = head[7:0];
  assign X2      = head[15:8];
  assign X3      = head[23:16];
  assign X4      = head[31:24];
  assign partial = cnt;

endmodule

// File: tb/tb_vec_packer.sv
// Bench for vec_packer: table vectors, corner sequences and a
// random stream checked against a queue-based model.
module tb_vec_packer;

  localparam int DEPTH = 2;

  logic              clk = 1'b0;
  logic              arst_n = 1'b0;
  logic signed [7:0] din = '0;
  logic              din_valid = 1'b0;
  logic              din_ready;
  logic              flush = 1'b0;
  logic signed [7:0] X1, X2, X3, X4;
  logic              valid;
  logic              ready = 1'b0;
  logic [1:0]        level;
  logic [1:0]        partial;

  vec_packer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .arst_n(arst_n),
    .din(din),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .flush(flush),
    .X1(X1),
    .X2(X2),
    .X3(X3),
    .X4(X4),
    .valid(valid),
    .ready(ready),
    .level(level),
    .partial(partial)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  int          asm_q[$];
  logic [31:0] vq[$];
  int          pops = 0;

  typedef struct {
    int n;
    int fmode;
    int has_vec;
    int s[4];
    int e[4];
  } vec_t;

  vec_t tbl[7];

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  // One clock: observe pre-edge state, advance the model.
  task automatic tick(output bit acc);
    bit          pp, sp;
    int          exp_rdy;
    logic [31:0] v;
    #2;
    acc = din_valid && din_ready;
    pp  = valid && ready;
    exp_rdy = (asm_q.size() < 3 || vq.size() < DEPTH || pp) ? 1 : 0;
    chk("din_ready", int'(din_ready), exp_rdy);
    chk("level", int'(level), vq.size());
    chk("partial", int'(partial), asm_q.size());
    chk("valid", int'(valid), (vq.size() > 0) ? 1 : 0);
    sp = vq.size() < DEPTH || pp;
    if (pp) begin
      pops++;
      if (vq.size() == 0)
        chk("pop_empty", 1, 0);
      else begin
        chk("head", int'({X4, X3, X2, X1}), int'(vq[0]));
        void'(vq.pop_front());
      end
    end
    if (acc)
      asm_q.push_back(int'(din));
    if (asm_q.size() == 4 || (flush && asm_q.size() > 0 && sp)) begin
      v = '0;
      for (int i = 0; i < asm_q.size(); i++)
        v[8*i +: 8] = 8'(asm_q[i]);
      vq.push_back(v);
      asm_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic send(int val, bit fl);
    bit a = 1'b0;
    din       = 8'(val);
    din_valid = 1'b1;
    flush     = fl;
    for (int i = 0; i < 50; i++) begin
      tick(a);
      if (a) break;
    end
    if (!a) chk("send_timeout", 0, 1);
    din_valid = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic idle(int n);
    bit a;
    for (int i = 0; i < n; i++) tick(a);
  endtask

  task automatic drain();
    bit a;
    ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (vq.size() == 0) break;
      tick(a);
    end
    chk("drain_empty", vq.size(), 0);
    ready = 1'b0;
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    #1;
    chk("rst_valid", int'(valid), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_partial", int'(partial), 0);
    chk("rst_din_ready", int'(din_ready), 0);
    chk("rst_x1", int'(X1), 0);
    asm_q.delete();
    vq.delete();
    din_valid = 1'b0;
    flush     = 1'b0;
    ready     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    chk("rel_din_ready", int'(din_ready), 1);
  endtask

  initial begin
    bit a;
    int n;

    tbl[0] = '{4, 0, 1, '{10, -20, 30, -40}, '{10, -20, 30, -40}};
    tbl[1] = '{2, 1, 1, '{5, 6, 0, 0}, '{5, 6, 0, 0}};
    tbl[2] = '{3, 2, 1, '{5, 6, 7, 0}, '{5, 6, 7, 0}};
    tbl[3] = '{0, 1, 0, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
    tbl[4] = '{1, 2, 1, '{-128, 0, 0, 0}, '{-128, 0, 0, 0}};
    tbl[5] = '{3, 1, 1, '{127, -1, 9, 0}, '{127, -1, 9, 0}};
    tbl[6] = '{4, 2, 1, '{1, 2, 3, 4}, '{1, 2, 3, 4}};

    do_reset();

    foreach (tbl[k]) begin
      for (int i = 0; i < tbl[k].n; i++)
        send(tbl[k].s[i], tbl[k].fmode == 2 && i == tbl[k].n - 1);
      if (tbl[k].fmode == 1) begin
        flush = 1'b1;
        tick(a);
        flush = 1'b0;
      end
      if (tbl[k].has_vec != 0) begin
        chk($sformatf("t%0d_valid", k), int'(valid), 1);
        chk($sformatf("t%0d_x1", k), int'(X1), tbl[k].e[0]);
        chk($sformatf("t%0d_x2", k), int'(X2), tbl[k].e[1]);
        chk($sformatf("t%0d_x3", k), int'(X3), tbl[k].e[2]);
        chk($sformatf("t%0d_x4", k), int'(X4), tbl[k].e[3]);
        ready = 1'b1;
        tick(a);
        ready = 1'b0;
      end
      chk($sformatf("t%0d_level", k), int'(level), 0);
    end

    // Stream with ready high: visible one cycle after the 4th.
    ready = 1'b1;
    send(10, 0);
    send(-20, 0);
    send(30, 0);
    send(-40, 0);
    chk("rt_valid", int'(valid), 1);
    chk("rt_head", int'({X4, X3, X2, X1}), int'(32'hD81EEC0A));
    tick(a);
    chk("rt_level", int'(level), 0);
    ready = 1'b0;

    // Backpressure: 11 samples fit, the 12th is held.
    for (int i = 1; i <= 11; i++) send(i * 3, 0);
    chk("bp_level", int'(level), 2);
    chk("bp_partial", int'(partial), 3);
    din       = 8'(36);
    din_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(a);
      chk("bp_held", int'(a), 0);
    end
    pops  = 0;
    ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (a) din_valid = 1'b0;
      if (vq.size() == 0 && asm_q.size() == 0 && !din_valid) break;
      tick(a);
    end
    chk("bp_pops", pops, 3);
    ready = 1'b0;
    din_valid = 1'b0;

    // Full FIFO, 4th sample coincides with a pop, 20 vectors.
    for (int i = 0; i < 8; i++) send(100 + i, 0);
    for (int v = 0; v < 20; v++) begin
      send(v * 4, 0);
      send(v * 4 + 1, 0);
      send(-v * 4 - 2, 0);
      ready     = 1'b1;
      din       = 8'(-v * 4 - 3);
      din_valid = 1'b1;
      tick(a);
      chk("fp_accept", int'(a), 1);
      din_valid = 1'b0;
      ready     = 1'b0;
      chk("fp_level", int'(level), 2);
    end
    drain();

    // Reset with partial=2 and level=1 discards everything.
    for (int i = 0; i < 6; i++) send(50 + i, 0);
    chk("mr_level", int'(level), 1);
    chk("mr_partial", int'(partial), 2);
    do_reset();
    ready = 1'b1;
    send(-1, 0);
    send(-2, 0);
    send(-3, 0);
    send(-4, 0);
    chk("mr_new", int'({X4, X3, X2, X1}), int'(32'hFCFDFEFF));
    idle(3);
    chk("mr_level_after", int'(level), 0);
    ready = 1'b0;

    // Random stream against the model.
    n = 0;
    for (int i = 0; i < 60000 && n < 10000; i++) begin
      din_valid = $urandom_range(0, 3) != 0;
      din       = 8'($urandom);
      ready     = $urandom_range(0, 1) == 1;
      flush     = $urandom_range(0, 15) == 0;
      tick(a);
      if (a) n++;
    end
    chk("rnd_count", n, 10000);
    din_valid = 1'b0;
    flush     = 1'b1;
    ready     = 1'b1;
    tick(a);
    flush = 1'b0;
    drain();
    chk("rnd_partial", int'(partial), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
